// File: rtl/ir_pkg.sv
// ir_pkg: shared encodings and frame layout for the IR command scheduler
package ir_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, GAP} state_t;
  typedef enum logic [2:0] {MODE_AUTO, MODE_COOL, MODE_DRY, MODE_FAN, MODE_HEAT} mode_t;
  localparam logic [4:0] T_MIN = 5'd16;
  localparam logic [4:0] T_MAX = 5'd30;
  localparam int HI_LSB = 12;
  localparam int TC_LSB = 8;
  localparam int FAN_LSB = 4;
  localparam int PWR_BIT = 3;
  localparam int MODE_LSB = 0;
endpackage

// File: rtl/ir_frame_pack.sv
// ir_frame_pack: packs air-conditioner state into the 35+32-bit IR frame
module ir_frame_pack
  import ir_pkg::*;
#(
  parameter logic [22:0] CONST35_HI = 23'h410802,
  parameter logic [27:0] CONST32_LO = 28'h0400006
) (
  input  logic        power,
  input  logic [2:0]  mode,
  input  logic [1:0]  fan,
  input  logic [4:0]  temp,
  output logic [34:0] data35,
  output logic [31:0] data32
);
  logic [3:0] tcode, csum;
  assign tcode = 4'(temp - T_MIN);
  assign csum = {1'b0, mode} + tcode + {3'b0, power} + 4'h5;
  assign data32 = {csum, CONST32_LO};
  always_comb begin
    data35 = '0;
    data35[34:HI_LSB] = CONST35_HI;
    data35[TC_LSB +: 4] = tcode;
    data35[FAN_LSB +: 2] = fan;
    data35[PWR_BIT] = power;
    data35[MODE_LSB +: 3] = mode;
  end
endmodule

// File: rtl/ir_cmd_scheduler.sv
// ir_cmd_scheduler: owns AC state and schedules local/host IR frames with repeats and gaps
module ir_cmd_scheduler
  import ir_pkg::*;
#(
  parameter int unsigned REPEAT      = 2,
  parameter int unsigned GAP_CYC     = 10_000_000,
  parameter int unsigned TIMEOUT_CYC = 20_000_000,
  parameter logic [22:0] CONST35_HI  = 23'h410802,
  parameter logic [27:0] CONST32_LO  = 28'h0400006,
  parameter logic [4:0]  T_RESET     = 5'd26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_power,
  input  logic        key_mode,
  input  logic        key_fan,
  input  logic        key_up,
  input  logic        key_dn,
  input  logic        ext_req,
  input  logic [34:0] ext_data35,
  input  logic [31:0] ext_data32,
  output logic        ext_ack,
  output logic        tx_start,
  output logic [34:0] tx_data35,
  output logic [31:0] tx_data32,
  input  logic        tx_busy,
  input  logic        tx_done,
  output logic        power,
  output logic [1:0]  fan,
  output logic [2:0]  mode,
  output logic [4:0]  temp,
  output logic        sched_busy,
  output logic        err_timeout
);
  state_t state, state_n;
  logic pend, src_local, src_n, timeout, unused;
  logic k_mode, k_fan, k_up, k_dn, key_hit;
  logic [2:0] rep, rep_n;
  logic [31:0] cnt, cnt_n;
  logic [34:0] f35;
  logic [31:0] f32;
  ir_frame_pack #(.CONST35_HI(CONST35_HI), .CONST32_LO(CONST32_LO)) u_pack (
    .power(power), .mode(mode), .fan(fan), .temp(temp), .data35(f35), .data32(f32)
  );
  assign unused = tx_busy;
  assign k_mode = !key_power && power && key_mode;
  assign k_fan = !key_power && !key_mode && power && key_fan;
  assign k_up = !key_power && !key_mode && !key_fan && power && key_up;
  assign k_dn = !key_power && !key_mode && !key_fan && !key_up && power && key_dn;
  assign key_hit = key_power || k_mode || k_fan || k_up || k_dn;
  assign tx_start = state == START;
  assign ext_ack = state == LOAD && !src_local;
  assign sched_busy = state != IDLE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      power <= 1'b0;
      mode <= MODE_AUTO;
      fan <= '0;
      temp <= T_RESET;
      pend <= 1'b0;
    end else begin
      power <= power ^ key_power;
      mode <= !k_mode ? mode : mode == MODE_HEAT ? MODE_AUTO : mode + 3'd1;
      fan <= fan + {1'b0, k_fan};
      temp <= k_up && temp < T_MAX ? temp + 5'd1 : k_dn && temp > T_MIN ? temp - 5'd1 : temp;
      pend <= key_hit || (pend && !(state == LOAD && src_local));
    end
  // a key in the same cycle counts as pending so keys also reach tx_start in two cycles
  always_comb begin
    state_n = state;
    src_n = src_local;
    rep_n = rep;
    cnt_n = '0;
    timeout = 1'b0;
    case (state)
      IDLE: if (pend || key_hit) begin
        state_n = LOAD;
        src_n = 1'b1;
      end else if (ext_req) begin
        state_n = LOAD;
        src_n = 1'b0;
      end
      LOAD: begin
        state_n = START;
        rep_n = '0;
      end
      START: begin
        state_n = WAIT;
        cnt_n = 32'd1;
      end
      WAIT: if (tx_done) begin
        state_n = GAP;
        rep_n = rep + 3'd1;
      end else if (cnt == TIMEOUT_CYC - 1) begin
        state_n = GAP;
        rep_n = 3'(REPEAT);
        timeout = 1'b1;
      end else cnt_n = cnt + 32'd1;
      GAP: if (cnt == GAP_CYC - 1) state_n = rep < 3'(REPEAT) ? START : IDLE;
        else cnt_n = cnt + 32'd1;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      src_local <= 1'b0;
      rep <= '0;
      cnt <= '0;
      err_timeout <= 1'b0;
      tx_data35 <= '0;
      tx_data32 <= '0;
    end else begin
      state <= state_n;
      src_local <= src_n;
      rep <= rep_n;
      cnt <= cnt_n;
      err_timeout <= err_timeout || timeout;
      if (state == LOAD) begin
        tx_data35 <= src_local ? f35 : ext_data35;
        tx_data32 <= src_local ? f32 : ext_data32;
      end
    end
endmodule

// File: tb/tb_ir_cmd_scheduler.sv
// tb_ir_cmd_scheduler: directed and random checks against a behavioural AC/frame model
module tb_ir_cmd_scheduler;
  logic clk = 0, rst = 0, ext_req = 0, tx_done = 0, no_done = 0;
  logic [4:0] keys = '0;
  logic [34:0] ext_data35 = '0;
  logic [31:0] ext_data32 = '0;
  logic ext_ack, tx_start, tx_busy, power, sched_busy, err_timeout;
  logic [34:0] tx_data35;
  logic [31:0] tx_data32;
  logic [1:0] fan;
  logic [2:0] mode;
  logic [4:0] temp;
  typedef struct {int cyc; logic [34:0] d35; logic [31:0] d32;} tx_t;
  tx_t st[$];
  int cyc = 0, cd = 0, ncmp = 0, nfail = 0;
  int m_pow, m_mode, m_fan, m_temp;
  ir_cmd_scheduler #(.REPEAT(2), .GAP_CYC(20), .TIMEOUT_CYC(200)) dut (
    .clk(clk), .rst(rst), .key_power(keys[0]), .key_mode(keys[1]), .key_fan(keys[2]),
    .key_up(keys[3]), .key_dn(keys[4]), .ext_req(ext_req), .ext_data35(ext_data35),
    .ext_data32(ext_data32), .ext_ack(ext_ack), .tx_start(tx_start), .tx_data35(tx_data35),
    .tx_data32(tx_data32), .tx_busy(tx_busy), .tx_done(tx_done), .power(power), .fan(fan),
    .mode(mode), .temp(temp), .sched_busy(sched_busy), .err_timeout(err_timeout)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign tx_busy = cd != 0;
  // transmitter model: logs every tx_start, answers tx_done 50 cycles later
  always @(negedge clk)
    if (!rst) begin
      cd = 0;
      tx_done = 0;
    end else begin
      tx_done = 0;
      if (cd > 0) begin
        cd--;
        if (cd == 0 && !no_done) tx_done = 1;
      end
      if (tx_start) begin
        cd = 50;
        st.push_back('{cyc, tx_data35, tx_data32});
      end
    end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic m_reset();
    m_pow = 0; m_mode = 0; m_fan = 0; m_temp = 26;
  endtask
  task automatic m_key(input int k, output bit hon);
    hon = (k == 0) || (m_pow == 1);
    if (k == 0) m_pow = 1 - m_pow;
    else if (hon)
      case (k)
        1: m_mode = (m_mode + 1) % 5;
        2: m_fan = (m_fan + 1) % 4;
        3: m_temp = m_temp < 30 ? m_temp + 1 : 30;
        default: m_temp = m_temp > 16 ? m_temp - 1 : 16;
      endcase
  endtask
  function automatic logic [34:0] m35();
    longint v = (longint'(23'h410802) << 12) + (m_temp - 16) * 256 + m_fan * 16 + m_pow * 8 + m_mode;
    return v[34:0];
  endfunction
  function automatic logic [31:0] m32();
    int cs = (m_mode + m_temp - 16 + m_pow + 5) % 16;
    return (32'(cs) << 28) | 32'h0400006;
  endfunction
  task automatic key(input int k, output bit hon);
    m_key(k, hon);
    keys[k] = 1'b1;
    tick(1);
    keys = '0;
  endtask
  task automatic wait_idle();
    int quiet = 0, n = 0;
    while (quiet < 3 && n < 2000) begin
      tick(1);
      n++;
      quiet = sched_busy ? 0 : quiet + 1;
    end
    chk("wait_idle", 64'(sched_busy), 0);
  endtask
  task automatic chk_state(input string tag);
    chk({tag, "_power"}, 64'(power), 64'(m_pow));
    chk({tag, "_mode"}, 64'(mode), 64'(m_mode));
    chk({tag, "_fan"}, 64'(fan), 64'(m_fan));
    chk({tag, "_temp"}, 64'(temp), 64'(m_temp));
  endtask
  initial begin
    bit h;
    int c0, ack_c, a;
    logic [34:0] fa35, fb35;
    logic [31:0] fb32, fl32;
    m_reset();
    tick(3);
    chk_state("rst");
    chk("rst_start", 64'(tx_start), 0);
    chk("rst_d35", 64'(tx_data35), 0);
    chk("rst_ack", 64'(ext_ack), 0);
    chk("rst_err", 64'(err_timeout), 0);
    chk("rst_busy", 64'(sched_busy), 0);
    rst = 1;
    tick(2);
    // power-on frame: latency, content, two repeats spaced by the gap
    st.delete();
    c0 = cyc;
    key(0, h);
    wait_idle();
    chk("s1_n", 64'(st.size()), 2);
    chk("s1_lat", 64'(st[0].cyc), 64'(c0 + 2));
    chk("s1_lo12", 64'(st[0].d35[11:0]), 64'h A08);
    chk("s1_d32", 64'(st[0].d32), 64'h0400006);
    chk("s1_gap", 64'(st[1].cyc - st[0].cyc), 71);
    chk("s1_rep", 64'(st[1].d35), 64'(m35()));
    // temperature saturation and coalescing of a key burst
    st.delete();
    for (int i = 0; i < 6; i++) key(3, h);
    wait_idle();
    chk_state("s2");
    chk("s2_n", 64'(st.size()), 4);
    chk("s2_tc", 64'(st[3].d35[11:8]), 64'hE);
    chk("s2_d32", 64'(st[3].d32), 64'(m32()));
    key(0, h);
    wait_idle();
    st.delete();
    key(3, h);
    tick(10);
    chk("s2_off_n", 64'(st.size()), 0);
    chk("s2_off_temp", 64'(temp), 30);
    chk("s2_off_busy", 64'(sched_busy), 0);
    // key during WAIT of the first repeat
    key(0, h);
    wait_idle();
    st.delete();
    key(2, h);
    fa35 = m35();
    tick(11);
    key(1, h);
    fb35 = m35();
    fb32 = m32();
    wait_idle();
    chk("s3_n", 64'(st.size()), 4);
    chk("s3_old", 64'(st[1].d35), 64'(fa35));
    chk("s3_new", 64'(st[2].d35), 64'(fb35));
    chk("s3_new2", 64'(st[3].d35), 64'(fb35));
    chk("s3_d32", 64'(st[2].d32), 64'(fb32));
    // host request tied with a local key
    st.delete();
    ext_data35 = 35'({$urandom(), $urandom()});
    ext_data32 = $urandom();
    ext_req = 1;
    key(2, h);
    fa35 = m35();
    fl32 = m32();
    a = 0;
    while (!ext_ack && a < 500) begin
      tick(1);
      a++;
    end
    chk("s4_ack", 64'(ext_ack), 1);
    ack_c = cyc;
    ext_req = 0;
    wait_idle();
    chk("s4_n", 64'(st.size()), 4);
    chk("s4_loc", 64'(st[1].d35), 64'(fa35));
    chk("s4_loc32", 64'(st[0].d32), 64'(fl32));
    chk("s4_order", 64'(ack_c > st[1].cyc), 1);
    chk("s4_lat", 64'(st[2].cyc), 64'(ack_c + 1));
    chk("s4_e35", 64'(st[2].d35), 64'(ext_data35));
    chk("s4_e32", 64'(st[3].d32), 64'(ext_data32));
    chk("s4_hold", 64'(tx_data35), 64'(ext_data35));
    // transmitter never answers
    st.delete();
    no_done = 1;
    key(4, h);
    tick(1);
    chk("s5_start", 64'(tx_start), 1);
    tick(199);
    chk("s5_err0", 64'(err_timeout), 0);
    tick(1);
    chk("s5_err1", 64'(err_timeout), 1);
    wait_idle();
    chk("s5_n", 64'(st.size()), 1);
    no_done = 0;
    // random key traffic
    for (int r = 0; r < 12; r++) begin
      st.delete();
      key(int'($urandom_range(0, 4)), h);
      wait_idle();
      chk_state("rnd");
      chk("rnd_n", 64'(st.size()), h ? 2 : 0);
      if (h) begin
        chk("rnd_d35", 64'(st[1].d35), 64'(m35()));
        chk("rnd_d32", 64'(st[1].d32), 64'(m32()));
      end
    end
    // asynchronous reset during WAIT
    if (m_pow == 0) key(0, h);
    wait_idle();
    key(1, h);
    tick(9);
    #2 rst = 0;
    #1;
    m_reset();
    chk_state("s6");
    chk("s6_start", 64'(tx_start), 0);
    chk("s6_d35", 64'(tx_data35), 0);
    chk("s6_d32", 64'(tx_data32), 0);
    chk("s6_err", 64'(err_timeout), 0);
    tick(3);
    rst = 1;
    tick(1);
    st.delete();
    tick(30);
    chk("s6_quiet", 64'(st.size()), 0);
    chk("s6_busy", 64'(sched_busy), 0);
    key(0, h);
    wait_idle();
    chk("s6_n", 64'(st.size()), 2);
    chk("s6_f35", 64'(st[0].d35), 64'(m35()));
    chk("s6_f32", 64'(st[0].d32), 64'(m32()));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/ir_cmd_scheduler.md
Name: ir_cmd_scheduler

Overview:
- Owns the air-conditioner state (power, mode, fan, setpoint) and turns front-panel key pulses and external host commands into 35+32-bit IR frames.
- Hands each frame to the existing IR frame transmitter through a start/busy/done handshake.
- Arbitrates local keys against the external requester, coalesces key bursts, repeats each frame and enforces an inter-frame gap.
- Sits between the debounced key/UART front end and the IR transmitter, in the 100 MHz domain.

Parameters:
- REPEAT, 2: transmissions per frame (1..7).
- GAP_CYC, 10_000_000: idle cycles after every transmission (100 ms).
- TIMEOUT_CYC, 20_000_000: max cycles from tx_start to tx_done before abort.
- CONST35_HI, 23'h410802: fixed bits 34:12 of data35.
- CONST32_LO, 28'h0400006: fixed bits 27:0 of data32.
- T_RESET, 26: setpoint after reset, in °C.

Ports:
- clk  in  1  100 MHz clock
- rst  in  1  asynchronous, active-low reset
- key_power, key_mode, key_fan, key_up, key_dn  in  1 each  debounced single-cycle key pulses
- ext_req  in  1  host frame request, level, held until ext_ack
- ext_data35  in  35  host frame part 1
- ext_data32  in  32  host frame part 2
- ext_ack  out  1  one-cycle pulse; host frame latched
- tx_start  out  1  one-cycle pulse to transmitter
- tx_data35  out  35  frame part 1, stable from tx_start until tx_done
- tx_data32  out  32  frame part 2, same stability rule
- tx_busy  in  1  transmitter busy (status only)
- tx_done  in  1  one-cycle end-of-frame pulse
- power, fan  out  1, 2  current state
- mode  out  3  current state
- temp  out  5  current state, °C
- sched_busy  out  1  high in any state other than IDLE
- err_timeout  out  1  sticky; cleared only by reset

Behaviour:
- Reset (async, rst=0) drives: power=0, mode=0, fan=0, temp=T_RESET, all pending flags 0, tx_start=0, tx_data*=0, ext_ack=0, err_timeout=0, state IDLE, repeat and gap counters 0.
- Key handling, every cycle in any state; only the highest-priority pulse in a cycle is honoured, priority power > mode > fan > up > dn:
  - power toggles power.
  - mode: 0..4, wraps 4→0.
  - fan: 0..3, wraps.
  - up/dn: saturate at 30/16.
  - Non-power keys are ignored while power=0.
  - Any honoured key sets pend_local.
- Frame build, combinational from state registers, sampled in LOAD:
  - tcode = temp−16 (4 bits).
  - data35 = {CONST35_HI, tcode, 2'b00, fan, power, mode}, bits 11:8 / 7:6 / 5:4 / 3 / 2:0.
  - csum = (mode + tcode + power + 4'h5) mod 16.
  - data32 = {csum, CONST32_LO}.
- FSM states and transitions:
  - IDLE: if pend_local, go to LOAD with src=local. Else if ext_req, go to LOAD with src=ext. Local always wins a same-cycle tie.
  - LOAD (1 cycle):
    - src=local: capture the built frame into tx_data*, clear pend_local. A key in this same cycle updates state and re-sets pend_local, so a fresh frame follows.
    - src=ext: capture ext_data*, pulse ext_ack. rep=0.
  - START (1 cycle): tx_start=1, then WAIT.
  - WAIT:
    - On tx_done: rep+1, go to GAP.
    - If TIMEOUT_CYC cycles pass without tx_done: set err_timeout, rep=REPEAT (abandon frame), go to GAP.
  - GAP: count GAP_CYC cycles, then:
    - rep<REPEAT: go to START, resending the same latched frame.
    - Otherwise go to IDLE.
- Latency: IDLE to tx_start is 2 cycles after the triggering pulse or ext_req.
- Coalescing: keys arriving during LOAD..GAP only update state and pend_local. One frame carrying the latest state is sent after the current repeats finish.
- tx_done outside WAIT is ignored. tx_data* is never changed outside LOAD.
- ext_req is not sampled outside IDLE. The host holds it until ext_ack.
- Reset mid-transmission: outputs return to reset values immediately. The transmitter is reset by the same rst.

Decomposition:
- Shared package ir_pkg holds:
  - State encoding: IDLE, LOAD, START, WAIT, GAP.
  - Mode encodings: AUTO=0, COOL=1, DRY=2, FAN=3, HEAT=4.
  - Temperature limits 16/30.
  - Frame field bit positions.
- Sub-module ir_frame_pack (combinational: state → data35/data32, including csum) so the bench and RTL share packing.
- Counters and FSM stay in the top module.

Test Plan (bench uses GAP_CYC=20, TIMEOUT_CYC=200, REPEAT=2, transmitter model answers tx_done 50 cycles after tx_start):
1. Reset, then key_power pulse → tx_start 2 cycles later; data35[11:0]=12'hA08, data32=32'h0400006 (csum 0); exactly 2 tx_start pulses separated by GAP; then IDLE, sched_busy=0.
2. Power on, 6 key_up pulses → temp saturates at 30, tcode=E; frames carry data35[11:8]=4'hE. Power off then key_up → temp unchanged, no frame.
3. key_mode during WAIT of the first repeat → second repeat still sends the old frame; then one new frame with mode=1 follows; no third old frame.
4. ext_req held with key_fan in the same IDLE cycle → local frame first; ext_ack only after local repeats finish; tx_data35/32 equal ext_data35/32.
5. Model withholds tx_done → err_timeout=1 at cycle 200 after tx_start; no retry of that frame; FSM returns to IDLE after GAP.
6. rst low during WAIT → tx_start=0, tx_data*=0, power=0, temp=26 asynchronously; after release, no frame until a new key or ext_req.
